gcd_ctrl: RTL and testbench

FSM controller that sequences the subtract-and-compare GCD datapath. Accepts a start request with operands on xin/yin. Drives the datapath mux selects and register loads from the datapath eqflg/ltflg flags until x==y, then loads the gcd register. Adds a ready/start/done handshake, zero-operand rejection, an iteration-count watchdog and abort.

---
 rtl/gcd_ctrl.sv | 115 +++++++++++
 tb/tb_gcd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtract-and-compare GCD datapath: start/ready/done
// handshake, zero-operand rejection, iteration watchdog and abort.
module gcd_ctrl #(
  parameter int WIDTH    = 4,
  parameter int MAX_ITER = 15,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic             eqflg,
  input  logic             ltflg,
  output logic             xmsel,
  output logic             ymsel,
  output logic             xld,
  output logic             yld,
  output logic             gld,
  output logic             dp_clr,
  output logic             ready,
  output logic             done,
  output logic             err,
  output logic [CW-1:0]    iter_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   iter_nxt;
  logic            err_nxt;
  logic            abort_taken;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
      err      <= err_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    iter_nxt    = iter_cnt;
    err_nxt     = err;
    xmsel       = 1'b0;
    ymsel       = 1'b0;
    xld         = 1'b0;
    yld         = 1'b0;
    gld         = 1'b0;
    abort_taken = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          iter_nxt = '0;
          if (xin == '0 || yin == '0) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            xmsel     = 1'b1;
            ymsel     = 1'b1;
            xld       = 1'b1;
            yld       = 1'b1;
            err_nxt   = 1'b0;
            state_nxt = CMP;
          end
        end
      end

      // Priority: abort, then equality, then watchdog, then one subtract step.
      CMP: begin
        if (abort) begin
          abort_taken = 1'b1;
          state_nxt   = IDLE;
        end else if (eqflg) begin
          gld       = 1'b1;
          state_nxt = DONE;
        end else if (iter_cnt == CW'(MAX_ITER)) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (ltflg) begin
          yld      = 1'b1;
          iter_nxt = iter_cnt + 1'b1;
        end else begin
          xld      = 1'b1;
          iter_nxt = iter_cnt + 1'b1;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase

    dp_clr = !clr || abort_taken;
  end

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_gcd_ctrl.sv
// Randomized scoreboard bench for gcd_ctrl; a small datapath model supplies
// the flags, and expected results come from a Euclid-based reference.
module tb_gcd_ctrl;

  localparam int WIDTH    = 4;
  localparam int MAX_ITER = 10;
  localparam int CW       = 8;

  logic             clk;
  logic             clr, start, abort;
  logic [WIDTH-1:0] xin, yin;
  logic             eqflg, ltflg;
  logic             xmsel, ymsel, xld, yld, gld, dp_clr, ready, done, err;
  logic [CW-1:0]    iter_cnt;

  typedef struct {
    int gcd;
    int err;
    int iter;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  gcd_ctrl #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .CW(CW)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .xin(xin), .yin(yin), .eqflg(eqflg), .ltflg(ltflg),
    .xmsel(xmsel), .ymsel(ymsel), .xld(xld), .yld(yld), .gld(gld),
    .dp_clr(dp_clr), .ready(ready), .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath environment: x/y/gcd registers driven by the controller strobes.
  logic [WIDTH-1:0] xr, yr, gr;
  always @(posedge clk) begin
    if (dp_clr) begin
      xr <= '0;
      yr <= '0;
      gr <= '0;
    end else begin
      if (xld) xr <= xmsel ? xin : xr - yr;
      if (yld) yr <= ymsel ? yin : yr - xr;
      if (gld) gr <= xr;
    end
  end
  assign eqflg = (xr == yr);
  assign ltflg = (xr < yr);

  function automatic logic [4:0] strobes();
    return {xmsel, ymsel, xld, yld, gld};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: subtract-GCD step count equals the sum of Euclid quotients minus one.
  function automatic void ref_gcd(input int a, input int b, output int g, output int steps);
    int t;
    steps = 0;
    while (b != 0) begin
      steps += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
    steps -= 1;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      next_cycle();
      n++;
    end
    if (n >= 100) check("ready_timeout", ready, 1);
  endtask

  // Issue one request; returns accept cycle and number of CMP cycles.
  // Leaves the caller #1 into the cycle after the accept with start low.
  task automatic issue(input int a, input int b, output int t, output int cmp_cycles);
    exp_t e;
    int   g, steps;
    wait_ready();
    start = 1'b1;
    xin   = WIDTH'(a);
    yin   = WIDTH'(b);
    t     = cyc;
    if (a == 0 || b == 0) begin
      e = '{gcd: 0, err: 1, iter: 0, cyc: t + 1};
      cmp_cycles = 0;
    end else begin
      ref_gcd(a, b, g, steps);
      if (steps <= MAX_ITER) e = '{gcd: g, err: 0, iter: steps, cyc: t + steps + 2};
      else                   e = '{gcd: g, err: 1, iter: MAX_ITER, cyc: t + MAX_ITER + 2};
      cmp_cycles = e.cyc - t - 1;
    end
    sb.push_back(e);
    #1;
    check("accept_strobes", strobes(), (a == 0 || b == 0) ? 5'b00000 : 5'b11110);
    next_cycle();
    start = 1'b0;
    xin   = WIDTH'($urandom);
    yin   = WIDTH'($urandom);
  endtask

  // Scoreboard monitor: compare on every done pulse, away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("err", err, e.err);
        check("iter_cnt", iter_cnt, e.iter);
        check("done_strobes", strobes(), 0);
        if (e.err == 0) check("gcd", gr, e.gcd);
      end
    end
  end

  initial begin
    int t, c, k, a, b;
    clr = 1'b0; start = 1'b0; abort = 1'b0; xin = '0; yin = '0;

    next_cycle();
    next_cycle();
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_iter", iter_cnt, 0);
    check("rst_err", err, 0);
    check("rst_dp_clr", dp_clr, 1);
    clr = 1'b1;
    #1;
    check("run_dp_clr", dp_clr, 0);

    // Directed 12,8: x-subtract, y-subtract, gld, done.
    issue(12, 8, t, c);
    #1; check("c1_strobes", strobes(), 5'b00100);
    next_cycle(); #1; check("c2_strobes", strobes(), 5'b00010);
    next_cycle(); #1; check("c3_strobes", strobes(), 5'b00001);

    issue(7, 7, t, c);
    issue(15, 1, t, c);   // 14 steps, watchdog error
    issue(11, 1, t, c);   // exactly MAX_ITER steps: succeeds
    issue(12, 1, t, c);   // MAX_ITER+1 steps: watchdog error

    // Zero operand rejection, err held in IDLE, then cleared by next accept.
    issue(0, 9, t, c);
    #1; check("zero_strobes", strobes(), 0);
    next_cycle(); next_cycle();
    check("err_held", err, 1);
    issue(9, 6, t, c);
    #1; check("err_cleared", err, 0);

    // Abort in cycle 2 of a 12,8 run.
    issue(12, 8, t, c);
    next_cycle();
    abort = 1'b1;
    #1;
    check("abort_dp_clr", dp_clr, 1);
    check("abort_strobes", strobes(), 0);
    sb.delete(sb.size() - 1);
    next_cycle();
    abort = 1'b0;
    check("abort_ready", ready, 1);

    // Start pulses during CMP and DONE are ignored.
    issue(15, 1, t, c);
    for (int i = 0; i <= c; i++) begin
      start = 1'b1; xin = 4'd3; yin = 4'd3;
      next_cycle();
    end
    start = 1'b0;
    #1;
    check("ign_ready", ready, 1);
    check("ign_iter_held", iter_cnt, MAX_ITER);

    // Reset in cycle 2 of a 15,1 run.
    issue(15, 1, t, c);
    next_cycle();
    clr = 1'b0;
    #1;
    check("midrst_dp_clr", dp_clr, 1);
    sb.delete(sb.size() - 1);
    next_cycle();
    check("midrst_ready", ready, 1);
    clr = 1'b1;
    next_cycle();
    check("midrst_iter", iter_cnt, 0);
    check("midrst_err", err, 0);
    check("midrst_dp_clr_off", dp_clr, 0);

    // Randomized runs with occasional aborts and ignored aborts in DONE.
    for (int n = 0; n < 60; n++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) next_cycle();
      a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      issue(a, b, t, c);
      if (c > 0 && $urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, c);
        for (int i = 1; i < k; i++) next_cycle();
        abort = 1'b1;
        #1;
        check("rnd_abort_dp_clr", dp_clr, 1);
        sb.delete(sb.size() - 1);
        next_cycle();
        abort = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < c; i++) next_cycle();
        abort = 1'b1;
        #1;
        check("done_abort_ignored", dp_clr, 0);
        next_cycle();
        abort = 1'b0;
      end
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) next_cycle();
    check("drain", sb.size(), 0);
    next_cycle();
    next_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
